// File: rtl/range_parser.sv
// Byte-serial ASCII parser for "lo-hi,lo-hi,...\n" range lists.
// Each range is presented as binary min/max plus the even-rounded digit
// length of min on a valid/ready port.
// Optional feature macro: PARSE_ERR_EN adds a sticky parse_err output.
module range_parser #(
    parameter int unsigned VAL_W = 40,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             rng_valid,
    input  logic             rng_ready,
    output logic [VAL_W-1:0] min,
    output logic [VAL_W-1:0] max,
    output logic [LEN_W-1:0] adjLen,
`ifdef PARSE_ERR_EN
    output logic             parse_err,
`endif
    output logic             list_done
);

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    localparam int unsigned ADJ_MIN = 2;
    localparam int unsigned ADJ_CAP = 14;
    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_MIN  = 2'd0,
        S_MAX  = 2'd1,
        S_EMIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [VAL_W-1:0]  acc_q, acc_d;
    logic [VAL_W-1:0]  lo_q, lo_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [VAL_W-1:0]  min_q, min_d;
    logic [VAL_W-1:0]  max_q, max_d;
    logic [LEN_W-1:0]  adj_q, adj_d;
    logic              nl_q, nl_d;
    logic              done_q, done_d;

    logic              take;
    logic              is_digit;
    logic              is_term;
    logic [3:0]        digit;
    logic [VAL_W-1:0]  acc_mac;

    // Round a digit count up to even, floor of 2, capped at 14.
    function automatic logic [LEN_W-1:0] round_len(input logic [LEN_W-1:0] c);
        logic [LEN_W:0] r;
        if (c <= LEN_W'(ADJ_MIN))
            r = (LEN_W+1)'(ADJ_MIN);
        else if (c[0])
            r = {1'b0, c} + (LEN_W+1)'(1);
        else
            r = {1'b0, c};
        if (r > (LEN_W+1)'(ADJ_CAP))
            r = (LEN_W+1)'(ADJ_CAP);
        return r[LEN_W-1:0];
    endfunction

    // Byte classification and decimal multiply-accumulate (wraps mod 2^VAL_W).
    always_comb begin
        take     = in_valid && (state_q != S_EMIT);
        is_digit = (in_data >= CH_0) && (in_data <= CH_9);
        is_term  = (in_data == CH_COMMA) || (in_data == CH_LF);
        digit    = in_data[3:0];
        acc_mac  = acc_q * VAL_W'(10) + VAL_W'(digit);
    end

`ifdef PARSE_ERR_EN
    logic              err_q, err_d;
    logic [VAL_W+3:0]  prod_wide;
    logic              ovf;
    logic              legal;

    // Sticky error: illegal byte, repeated '-', or accumulator overflow.
    always_comb begin
        prod_wide = {4'b0000, acc_q} * (VAL_W+4)'(10) + (VAL_W+4)'(digit);
        ovf       = |prod_wide[VAL_W+3:VAL_W];
        legal     = is_digit || is_term || (in_data == CH_DASH) ||
                    (in_data == CH_CR) || (in_data == CH_SP);
        err_d     = err_q;
        if (take && (!legal || (is_digit && ovf) ||
                     (state_q == S_MAX && in_data == CH_DASH)))
            err_d = 1'b1;
    end

    assign parse_err = err_q;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        adj_d   = adj_q;
        nl_d    = nl_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_MIN: begin
                if (take) begin
                    if (is_digit) begin
                        acc_d = acc_mac;
                        // leading zeros do not count toward the length
                        if (((acc_q != '0) || (digit != 4'd0)) && (cnt_q != CNT_MAX))
                            cnt_d = cnt_q + LEN_W'(1);
                    end else if (in_data == CH_DASH) begin
                        lo_d    = acc_q;
                        acc_d   = '0;
                        state_d = S_MAX;
                    end else if (is_term) begin
                        min_d   = acc_q;
                        max_d   = acc_q;
                        adj_d   = round_len(cnt_q);
                        nl_d    = (in_data == CH_LF);
                        state_d = S_EMIT;
                    end
                end
            end
            S_MAX: begin
                if (take) begin
                    if (is_digit) begin
                        acc_d = acc_mac;
                    end else if (is_term) begin
                        min_d   = lo_q;
                        max_d   = acc_q;
                        adj_d   = round_len(cnt_q);
                        nl_d    = (in_data == CH_LF);
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (rng_ready) begin
                    acc_d   = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                    done_d  = nl_q;
                    state_d = S_MIN;
                end
            end
            default: state_d = S_MIN;
        endcase
    end

    // State and datapath registers; reset drops any partial range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_MIN;
            acc_q   <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            adj_q   <= '0;
            nl_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef PARSE_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            adj_q   <= adj_d;
            nl_q    <= nl_d;
            done_q  <= done_d;
`ifdef PARSE_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready  = (state_q != S_EMIT);
    assign rng_valid = (state_q == S_EMIT);
    assign min       = min_q;
    assign max       = max_q;
    assign adjLen    = adj_q;
    assign list_done = done_q;

endmodule
